// File: rtl/wb_ram_arbiter.sv
// rtl/wb_ram_arbiter.sv - N-master Wishbone B3 round-robin arbiter with burst-aware quantum preemption
// Optional slave watchdog returning err on a hung access is built when WB_ARB_TIMEOUT_EN is defined.
module wb_ram_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int QUANTUM     = 4,
  parameter int TIMEOUT     = 256
) (
  input  logic                      wb_clk,
  input  logic                      wb_rst_n,
  input  logic [NUM_MASTERS*AW-1:0] wbm_adr_i,
  input  logic [NUM_MASTERS*DW-1:0] wbm_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS*3-1:0]  wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]  wbm_bte_i,
  input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
  input  logic [NUM_MASTERS-1:0]    wbm_we_i,
  output logic [DW-1:0]             wbm_dat_o,
  output logic [NUM_MASTERS-1:0]    wbm_ack_o,
  output logic [NUM_MASTERS-1:0]    wbm_err_o,
  output logic [NUM_MASTERS-1:0]    wbm_rty_o,
  output logic [AW-1:0]             wbs_adr_o,
  output logic [DW-1:0]             wbs_dat_o,
  output logic [DW/8-1:0]           wbs_sel_o,
  output logic [2:0]                wbs_cti_o,
  output logic [1:0]                wbs_bte_o,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  output logic                      wbs_we_o,
  input  logic [DW-1:0]             wbs_dat_i,
  input  logic                      wbs_ack_i,
  output logic [NUM_MASTERS-1:0]    grant_o
);

  localparam int PW      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int QW      = $clog2(QUANTUM + 2);
  localparam int SW      = DW / 8;
  localparam int QLAST_I = (QUANTUM > 0) ? QUANTUM - 1 : 0;

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t                 r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
  logic [PW-1:0]          r_ptr, w_ptr_nxt;
  logic [QW-1:0]          r_qcnt;
  logic [PW-1:0]          w_win_idx;
  logic                   w_win_found;
  logic                   w_own, w_g_cyc, w_other, w_compl, w_preempt, w_wd_fire;
  logic [2:0]             w_g_cti;

  // While a grant is held, r_ptr is the granted index, so it doubles as the mux select.
  assign w_own     = (r_state == S_OWN);
  assign w_g_cyc   = w_own & wbm_cyc_i[r_ptr];
  assign w_g_cti   = wbm_cti_i[int'(r_ptr)*3 +: 3];
  assign w_other   = |(wbm_cyc_i & ~r_grant);
  assign w_compl   = w_own & wbs_ack_i & ((w_g_cti == 3'b000) | (w_g_cti == 3'b111));
  assign w_preempt = (QUANTUM != 0) & w_compl & (r_qcnt == QW'(QLAST_I)) & w_other;

  always_comb begin
    int w_idx;
    w_idx       = 0;
    w_win_idx   = r_ptr;
    w_win_found = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      w_idx = (int'(r_ptr) + i) % NUM_MASTERS;
      if (!w_win_found && wbm_cyc_i[w_idx]) begin
        w_win_found = 1'b1;
        w_win_idx   = PW'(w_idx);
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT) + 1;
  logic [WW-1:0] r_wdog;

  assign w_wd_fire = w_own & wbs_stb_o & ~wbs_ack_i & (r_wdog == WW'(TIMEOUT - 1));

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n || !w_own || wbs_ack_i) begin
      r_wdog <= '0;
    end else if (wbs_stb_o) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end
`else
  assign w_wd_fire = 1'b0;
`endif

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n || !w_own) begin
      r_qcnt <= '0;
    end else if (w_compl && r_qcnt != QW'(QUANTUM)) begin
      r_qcnt <= r_qcnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_win_found) begin
          w_state_nxt            = S_OWN;
          w_grant_nxt            = '0;
          w_grant_nxt[w_win_idx] = 1'b1;
          w_ptr_nxt              = w_win_idx;
        end
      end
      default: begin
        if (!w_g_cyc || w_preempt || w_wd_fire) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
        end
      end
    endcase
  end

  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_we_o  = 1'b0;
    if (w_own) begin
      wbs_adr_o = wbm_adr_i[int'(r_ptr)*AW +: AW];
      wbs_dat_o = wbm_dat_i[int'(r_ptr)*DW +: DW];
      wbs_sel_o = wbm_sel_i[int'(r_ptr)*SW +: SW];
      wbs_cti_o = w_g_cti;
      wbs_bte_o = wbm_bte_i[int'(r_ptr)*2 +: 2];
      wbs_cyc_o = w_g_cyc;
      wbs_stb_o = wbm_stb_i[r_ptr];
      wbs_we_o  = wbm_we_i[r_ptr];
    end
    wbm_ack_o = {NUM_MASTERS{wbs_ack_i & wb_rst_n}} & r_grant;
    wbm_err_o = {NUM_MASTERS{w_wd_fire & wb_rst_n}} & r_grant;
    wbm_rty_o = '0;
    wbm_dat_o = wbs_dat_i;
    grant_o   = r_grant;
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// tb/tb_wb_ram_arbiter.sv - directed self-checking bench for wb_ram_arbiter (3 masters, QUANTUM=4, TIMEOUT=16)
module tb_wb_ram_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 32;

  logic            wb_clk = 1'b0;
  logic            wb_rst_n = 1'b0;
  logic [N*AW-1:0] adr;
  logic [N*DW-1:0] dat;
  logic [N*DW/8-1:0] sel;
  logic [N*3-1:0]  cti;
  logic [N*2-1:0]  bte;
  logic [N-1:0]    cyc, stb, we;
  logic [DW-1:0]   wbm_dat_o;
  logic [N-1:0]    wbm_ack_o, wbm_err_o, wbm_rty_o, grant_o;
  logic [AW-1:0]   wbs_adr_o;
  logic [DW-1:0]   wbs_dat_o, wbs_dat_i;
  logic [DW/8-1:0] wbs_sel_o;
  logic [2:0]      wbs_cti_o;
  logic [1:0]      wbs_bte_o;
  logic            wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_ack_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 wb_clk = ~wb_clk;

  wb_ram_arbiter #(.NUM_MASTERS(N), .DW(DW), .AW(AW), .QUANTUM(4), .TIMEOUT(16)) u_dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .wbm_adr_i(adr), .wbm_dat_i(dat), .wbm_sel_i(sel), .wbm_cti_i(cti), .wbm_bte_i(bte),
    .wbm_cyc_i(cyc), .wbm_stb_i(stb), .wbm_we_i(we),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_cti_o(wbs_cti_o),
    .wbs_bte_o(wbs_bte_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .grant_o(grant_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic master(input int k, input logic c, input logic s, input logic [2:0] t);
    cyc[k] = c;
    stb[k] = s;
    cti[k*3 +: 3] = t;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      adr[k*AW +: AW] = 32'h1000_0000 + 32'(k) * 32'h100;
      dat[k*DW +: DW] = 32'hA000_0000 + 32'(k);
    end
    sel = '1; cti = '0; bte = '0; cyc = '0; stb = '0; we = '0;
    wbs_dat_i = '0; wbs_ack_i = 1'b0;

    // reset state after first clock with reset low
    wb_rst_n = 1'b0;
    step();
    check("rst_grant", 64'(grant_o), 64'h0);
    check("rst_ack", 64'(wbm_ack_o), 64'h0);
    check("rst_err", 64'(wbm_err_o), 64'h0);
    check("rst_cyc", 64'(wbs_cyc_o), 64'h0);
    wb_rst_n = 1'b1;

    // round robin 1,2,0 from ptr=0 with one idle cycle between grants
    master(0, 1, 1, 3'b000); master(1, 1, 1, 3'b000); master(2, 1, 1, 3'b000);
    settle();
    check("rr_idle_first", 64'(grant_o), 64'h0);
    step();
    check("rr_grant1", 64'(grant_o), 64'h2);
    check("rr_adr1", 64'(wbs_adr_o), 64'h1000_0100);
    check("rr_dat1", 64'(wbs_dat_o), 64'hA000_0001);
    wbs_ack_i = 1'b1; wbs_dat_i = 32'hDEAD_BEEF;
    settle();
    check("rr_ack1", 64'(wbm_ack_o), 64'h2);
    check("rd_data", 64'(wbm_dat_o), 64'hDEAD_BEEF);
    step();
    master(1, 0, 0, 3'b000); wbs_ack_i = 1'b0;
    settle();
    check("rr_drop_cyc", 64'(wbs_cyc_o), 64'h0);
    check("rr_drop_grant", 64'(grant_o), 64'h2);
    step();
    check("rr_idle12", 64'(grant_o), 64'h0);
    step();
    check("rr_grant2", 64'(grant_o), 64'h4);
    wbs_ack_i = 1'b1;
    settle();
    check("rr_ack2", 64'(wbm_ack_o), 64'h4);
    step();
    master(2, 0, 0, 3'b000); wbs_ack_i = 1'b0;
    step();
    check("rr_idle20", 64'(grant_o), 64'h0);
    step();
    check("rr_grant0", 64'(grant_o), 64'h1);
    wbs_ack_i = 1'b1;
    settle();
    check("rr_ack0", 64'(wbm_ack_o), 64'h1);
    step();
    master(0, 0, 0, 3'b000); wbs_ack_i = 1'b0;
    step();
    check("rr_idle_end", 64'(grant_o), 64'h0);

    // quantum: master 0 singles while master 2 waits
    master(0, 1, 1, 3'b000);
    step();
    check("q_grant0", 64'(grant_o), 64'h1);
    master(2, 1, 1, 3'b000); wbs_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("q_ack0", 64'(wbm_ack_o), 64'h1);
      step();
    end
    settle();
    check("q_yield_idle", 64'(grant_o), 64'h0);
    check("q_no_ack5", 64'(wbm_ack_o), 64'h0);
    wbs_ack_i = 1'b0;
    step();
    check("q_grant2", 64'(grant_o), 64'h4);
    check("q_adr2", 64'(wbs_adr_o), 64'h1000_0200);
    master(2, 0, 0, 3'b000); master(0, 0, 0, 3'b000);
    step();
    step();
    check("q_idle_end", 64'(grant_o), 64'h0);

    // burst is never split: 3 singles leave counter at QUANTUM-1, then 8-beat burst
    master(1, 1, 1, 3'b000);
    step();
    check("b_grant1", 64'(grant_o), 64'h2);
    master(0, 1, 1, 3'b000); wbs_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("b_single_ack", 64'(wbm_ack_o), 64'h2);
      step();
    end
    for (int b = 0; b < 8; b++) begin
      master(1, 1, 1, (b == 7) ? 3'b111 : 3'b010);
      settle();
      check("b_hold_grant", 64'(grant_o), 64'h2);
      check("b_beat_ack", 64'(wbm_ack_o), 64'h2);
      step();
    end
    wbs_ack_i = 1'b0; master(1, 0, 0, 3'b000);
    settle();
    check("b_idle", 64'(grant_o), 64'h0);
    step();
    check("b_grant0", 64'(grant_o), 64'h1);
    master(0, 0, 0, 3'b000);
    step();
    step();
    check("b_idle_end", 64'(grant_o), 64'h0);

    // reset mid-burst on beat 3 of master 2
    master(2, 1, 1, 3'b010);
    step();
    check("r_grant2", 64'(grant_o), 64'h4);
    wbs_ack_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("r_beat_ack", 64'(wbm_ack_o), 64'h4);
      step();
    end
    wb_rst_n = 1'b0;
    settle();
    check("r_no_ack_leak", 64'(wbm_ack_o), 64'h0);
    step();
    wb_rst_n = 1'b1;
    master(0, 1, 1, 3'b000); master(1, 1, 1, 3'b000); master(2, 1, 1, 3'b000);
    settle();
    check("r_grant_clear", 64'(grant_o), 64'h0);
    check("r_cyc_clear", 64'(wbs_cyc_o), 64'h0);
    check("r_ack_clear", 64'(wbm_ack_o), 64'h0);
    wbs_ack_i = 1'b0;
    step();
    check("r_ptr0_grant1", 64'(grant_o), 64'h2);

    // hung slave: master 1 strobes, no ack
    for (int c = 1; c <= 16; c++) begin
`ifdef WB_ARB_TIMEOUT_EN
      check("wd_err", 64'(wbm_err_o), (c == 16) ? 64'h2 : 64'h0);
`else
      check("wd_err", 64'(wbm_err_o), 64'h0);
`endif
      step();
    end
`ifdef WB_ARB_TIMEOUT_EN
    check("wd_cyc_drop", 64'(wbs_cyc_o), 64'h0);
    check("wd_grant_drop", 64'(grant_o), 64'h0);
    check("wd_err_once", 64'(wbm_err_o), 64'h0);
`else
    check("wd_off_cyc", 64'(wbs_cyc_o), 64'h1);
    check("wd_off_grant", 64'(grant_o), 64'h2);
`endif
    check("rty_zero", 64'(wbm_rty_o), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
